// File: rtl/sort_pkg.sv
// Shared types and defaults for the in-place RAM bubble sorter.
// Holds the FSM state enum, default bus widths and the cycle-count width.
package sort_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 16;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_WR_A,
    S_WR_B,
    S_DONE
  } state_e;

endpackage

// File: rtl/sort_cycle_cnt.sv
// Saturating cycle counter: clr_i zeroes, en_i counts up, sticks at all-ones.
// Ports: clk_i, rst_ni, clr_i, en_i in; cnt_o [CNT_W] out.
module sort_cycle_cnt
  import sort_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/bubble_sort_ctrl.sv
// Bubble-sort controller that sorts N words in place in an async-read RAM.
// Ports: CLK100MHZ, rstn, run, mem_rdata in; mem_addr/wdata/we, busy, done, cnt out.
module bubble_sort_ctrl
  import sort_pkg::*;
#(
  parameter int N      = 256,
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int ASCEND = 1
) (
  input  logic             CLK100MHZ,
  input  logic             rstn,
  input  logic             run,
  input  logic [DW-1:0]    mem_rdata,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  output logic             mem_we,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);

  state_e        state_q, state_d;
  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] last_q, last_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic          sw_q, sw_d;

  logic cnt_clr;
  logic ooo;
  logic adv;
  logic more;
  logic again;

  // Strict compare: equal words never swap, keeping the sort stable.
  assign ooo = (ASCEND != 0) ? (a_q > mem_rdata)
                             : (a_q < mem_rdata);

  assign busy = (state_q != S_IDLE);

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    last_d    = last_q;
    a_d       = a_q;
    b_d       = b_q;
    sw_d      = sw_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    done      = 1'b0;
    cnt_clr   = 1'b0;
    adv       = 1'b0;
    more      = 1'b0;
    again     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          i_d     = '0;
          last_d  = AW'(N - 1);
          sw_d    = 1'b0;
          cnt_clr = 1'b1;
          state_d = S_RD_A;
        end
      end
      S_RD_A: begin
        mem_addr = i_q;
        a_d      = mem_rdata;
        state_d  = S_RD_B;
      end
      S_RD_B: begin
        mem_addr = i_q + 1'b1;
        b_d      = mem_rdata;
        if (ooo) begin
          sw_d    = 1'b1;
          state_d = S_WR_A;
        end else begin
          adv = 1'b1;
        end
      end
      S_WR_A: begin
        mem_addr  = i_q;
        mem_wdata = b_q;
        mem_we    = 1'b1;
        state_d   = S_WR_B;
      end
      S_WR_B: begin
        mem_addr  = i_q + 1'b1;
        mem_wdata = a_q;
        mem_we    = 1'b1;
        adv       = 1'b1;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pair finished: step within the pass, start a shorter
    // pass, or stop once a pass made no swaps.
    if (adv) begin
      more  = (i_q < (last_q - 1'b1));
      again = !more && sw_d && (last_q > AW'(1));
      unique case (1'b1)
        more: begin
          i_d     = i_q + 1'b1;
          state_d = S_RD_A;
        end
        again: begin
          last_d  = last_q - 1'b1;
          i_d     = '0;
          sw_d    = 1'b0;
          state_d = S_RD_A;
        end
        default: state_d = S_DONE;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      last_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sw_q    <= sw_d;
    end
  end

  sort_cycle_cnt u_cnt (
    .clk_i  (CLK100MHZ),
    .rst_ni (rstn),
    .clr_i  (cnt_clr),
    .en_i   (busy),
    .cnt_o  (cnt)
  );

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Bench for bubble_sort_ctrl: three instances (N=4 asc, N=4 desc, N=256 asc)
// with RAM models; expected results are queued and checked on each done pulse.
module tb_bubble_sort_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        run   [3];
  logic [7:0]  addr  [3];
  logic [15:0] wdata [3];
  logic [15:0] rdata [3];
  logic [15:0] cnt   [3];
  logic        we    [3];
  logic        busy  [3];
  logic        done  [3];

  logic [15:0] ram [3][256];
  logic [15:0] img [3][256];
  logic        load [3];

  typedef struct packed {
    logic [1:0]       inst;
    logic [15:0]      cnt;
    logic [31:0]      wr;
    logic [31:0]      bsy;
    logic [3:0][15:0] ram;
  } exp_t;

  exp_t sb [$];

  int n_run;
  int n_fail;
  int bsy_c  [3];
  int wr_c   [3];
  int n_cmpl [3];
  logic pend [3];

  bubble_sort_ctrl #(.N(4), .ASCEND(1)) u_a (
    .CLK100MHZ (clk),      .rstn   (rstn),
    .run       (run[0]),   .mem_rdata (rdata[0]),
    .mem_addr  (addr[0]),  .mem_wdata (wdata[0]),
    .mem_we    (we[0]),    .busy   (busy[0]),
    .done      (done[0]),  .cnt    (cnt[0])
  );

  bubble_sort_ctrl #(.N(4), .ASCEND(0)) u_b (
    .CLK100MHZ (clk),      .rstn   (rstn),
    .run       (run[1]),   .mem_rdata (rdata[1]),
    .mem_addr  (addr[1]),  .mem_wdata (wdata[1]),
    .mem_we    (we[1]),    .busy   (busy[1]),
    .done      (done[1]),  .cnt    (cnt[1])
  );

  bubble_sort_ctrl #(.N(256), .ASCEND(1)) u_c (
    .CLK100MHZ (clk),      .rstn   (rstn),
    .run       (run[2]),   .mem_rdata (rdata[2]),
    .mem_addr  (addr[2]),  .mem_wdata (wdata[2]),
    .mem_we    (we[2]),    .busy   (busy[2]),
    .done      (done[2]),  .cnt    (cnt[2])
  );

  assign rdata[0] = ram[0][addr[0]];
  assign rdata[1] = ram[1][addr[1]];
  assign rdata[2] = ram[2][addr[2]];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (load[k]) begin
        for (int j = 0; j < 256; j++) ram[k][j] <= img[k][j];
      end else if (we[k]) begin
        ram[k][addr[k]] <= wdata[k];
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_k(int k);
    exp_t e;
    int   bad;
    if (sb.size() == 0) begin
      n_run++;
      n_fail++;
      $display("FAIL unexpected_done: inst %0d, got done, want none", k);
      return;
    end
    e = sb.pop_front();
    chk("inst", k, int'(e.inst));
    chk("cnt", int'(cnt[k]), int'(e.cnt));
    chk("wr_cycles", wr_c[k], int'(e.wr));
    chk("busy_cycles", bsy_c[k], int'(e.bsy));
    if (k < 2) begin
      for (int j = 0; j < 4; j++)
        chk($sformatf("ram%0d[%0d]", k, j),
            int'(ram[k][j]), int'(e.ram[j]));
    end else begin
      bad = 0;
      for (int j = 0; j < 256; j++)
        if (ram[2][j] != 16'hFF00 + 16'(j)) bad++;
      chk("ram256_bad_words", bad, 0);
    end
    bsy_c[k] = 0;
    wr_c[k]  = 0;
    n_cmpl[k]++;
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rstn) begin
        bsy_c[k] = 0;
        wr_c[k]  = 0;
        pend[k]  = 1'b0;
      end else begin
        if (pend[k]) begin
          pend[k] = 1'b0;
          chk("done_one_cycle", int'(done[k]), 0);
          check_k(k);
        end
        if (busy[k]) bsy_c[k]++;
        if (we[k]) begin
          wr_c[k]++;
          if (k == 1)
            chk("no_equal_swap",
                int'(wdata[1] != ram[1][addr[1]]), 1);
        end
        if (done[k]) pend[k] = 1'b1;
      end
    end
  end

  task automatic load4(int k, int v0, int v1, int v2, int v3);
    img[k][0] = 16'(v0);
    img[k][1] = 16'(v1);
    img[k][2] = 16'(v2);
    img[k][3] = 16'(v3);
    load[k] = 1'b1;
    @(negedge clk);
    load[k] = 1'b0;
  endtask

  task automatic push(int k, int c, int w, int b,
                      int r0, int r1, int r2, int r3);
    exp_t e;
    e.inst   = 2'(k);
    e.cnt    = 16'(c);
    e.wr     = 32'(w);
    e.bsy    = 32'(b);
    e.ram[0] = 16'(r0);
    e.ram[1] = 16'(r1);
    e.ram[2] = 16'(r2);
    e.ram[3] = 16'(r3);
    sb.push_back(e);
  endtask

  task automatic pulse(int k);
    run[k] = 1'b1;
    @(negedge clk);
    run[k] = 1'b0;
  endtask

  task automatic wait_done(int k, int budget);
    int s;
    s = n_cmpl[k];
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (n_cmpl[k] != s) return;
    end
    n_run++;
    n_fail++;
    $display("FAIL timeout_inst%0d: got no done, want done in %0d",
             k, budget);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rstn   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      run[k]    = 1'b0;
      load[k]   = 1'b0;
      n_cmpl[k] = 0;
      for (int j = 0; j < 256; j++) img[k][j] = '0;
    end
    repeat (3) @(negedge clk);

    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", int'(busy[k]), 0);
      chk("rst_we", int'(we[k]), 0);
      chk("rst_cnt", int'(cnt[k]), 0);
    end
    chk("rst_addr", int'(addr[0]), 0);
    chk("rst_wdata", int'(wdata[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    rstn = 1'b1;
    @(negedge clk);

    // Already sorted: three compares, no writes.
    load4(0, 1, 2, 3, 4);
    push(0, 7, 0, 7, 1, 2, 3, 4);
    pulse(0);
    wait_done(0, 100);

    // Reversed: six swaps, 12 write cycles.
    load4(0, 4, 3, 2, 1);
    push(0, 25, 12, 25, 1, 2, 3, 4);
    pulse(0);
    wait_done(0, 100);

    // run held high through the sort must not restart it.
    load4(0, 4, 3, 2, 1);
    push(0, 25, 12, 25, 1, 2, 3, 4);
    run[0] = 1'b1;
    repeat (10) @(negedge clk);
    run[0] = 1'b0;
    wait_done(0, 100);
    repeat (2) @(negedge clk);
    chk("no_restart", int'(busy[0]), 0);

    // Reset during the first WR_A.
    load4(0, 4, 3, 2, 1);
    pulse(0);
    for (int c = 0; c < 20 && !we[0]; c++) @(negedge clk);
    chk("reached_wr_a", int'(we[0]), 1);
    rstn = 1'b0;
    #1;
    chk("abort_we", int'(we[0]), 0);
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_cnt", int'(cnt[0]), 0);
    chk("abort_addr", int'(addr[0]), 0);
    chk("abort_wdata", int'(wdata[0]), 0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_ram0", int'(ram[0][0]), 4);
    chk("abort_ram1", int'(ram[0][1]), 3);
    rstn = 1'b1;
    push(0, 25, 12, 25, 1, 2, 3, 4);
    pulse(0);
    wait_done(0, 100);

    // Descending with duplicates: only the 1/2 pair swaps.
    load4(1, 2, 2, 1, 2);
    push(1, 13, 2, 13, 2, 2, 2, 1);
    pulse(1);
    wait_done(1, 100);

    // Descending on ascending input: full reversal.
    load4(1, 1, 2, 3, 4);
    push(1, 25, 12, 25, 4, 3, 2, 1);
    pulse(1);
    wait_done(1, 100);

    // 256 words reversed: 32640 swaps, counter saturates.
    for (int j = 0; j < 256; j++) img[2][j] = 16'hFFFF - 16'(j);
    load[2] = 1'b1;
    @(negedge clk);
    load[2] = 1'b0;
    push(2, 16'hFFFF, 65280, 130561, 0, 0, 0, 0);
    pulse(2);
    wait_done(2, 140000);
    repeat (4) @(negedge clk);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/bubble_sort_ctrl.md
BUBBLE_SORT_CTRL -- requirements
Module: bubble_sort_ctrl

Interface
REQ-001 SHALL have parameter N, default 256: number of words sorted, addresses 0..N-1; legal range 2..256.
REQ-002 SHALL have parameter AW, default 8: address width.
REQ-003 SHALL have parameter DW, default 16: data width.
REQ-004 SHALL have parameter ASCEND, default 1: 1 = ascending unsigned order, 0 = descending.
REQ-005 SHALL have port CLK100MHZ, input, 1: the only clock, rising edge.
REQ-006 SHALL have port rstn, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port run, input, 1: start request, sampled each edge.
REQ-008 SHALL have port mem_rdata, input, DW: RAM read data, combinational (asynchronous-read) from mem_addr.
REQ-009 SHALL have port mem_addr, output, AW: RAM address.
REQ-010 SHALL have port mem_wdata, output, DW: RAM write data.
REQ-011 SHALL have port mem_we, output, 1: RAM write enable, written at the next rising edge.
REQ-012 SHALL have port busy, output, 1: sort in progress; the top-level mux gives this block RAM ownership while high.
REQ-013 SHALL have port done, output, 1: one-cycle completion pulse (FIN).
REQ-014 SHALL have port cnt, output, 16: clock cycles consumed by the last sort.

Function
REQ-015 SHALL implement states IDLE, RD_A, RD_B, WR_A, WR_B, DONE, with registers i (AW), last (AW), a_reg, b_reg (DW) and swapped (1).
REQ-016 SHALL, in IDLE with run=1, load i=0, last=N-1, swapped=0 and cnt=0, then enter RD_A.
REQ-017 SHALL ignore run in every state other than IDLE.
REQ-018 SHALL, in RD_A, drive mem_addr=i, capture a_reg=mem_rdata, and go to RD_B.
REQ-019 SHALL, in RD_B, drive mem_addr=i+1, capture b_reg=mem_rdata, and compare a_reg with mem_rdata.
REQ-020 SHALL treat a pair as out of order when a>b (ASCEND=1) or a<b (ASCEND=0).
REQ-021 SHALL never swap equal values, so the sort is stable.
REQ-022 SHALL, for an out-of-order pair, go RD_B -> WR_A -> WR_B and set swapped=1.
REQ-023 SHALL, in WR_A, drive mem_addr=i, mem_wdata=b_reg, mem_we=1.
REQ-024 SHALL, in WR_B, drive mem_addr=i+1, mem_wdata=a_reg, mem_we=1.
REQ-025 SHALL advance after RD_B (no swap) or WR_B: if i<last-1, set i=i+1 and go to RD_A; otherwise end the pass.
REQ-026 SHALL, at pass end, if the pass swapped (including the final pair) and last>1, set last=last-1, i=0, swapped=0 and go to RD_A; otherwise go to DONE.
REQ-027 SHALL, in DONE, assert done=1 for exactly one cycle, then go to IDLE.
REQ-028 SHALL hold mem_we=0, mem_addr=0, mem_wdata=0 in IDLE, RD_A, RD_B and DONE, except that mem_addr follows REQ-018/019.
REQ-029 SHALL drive busy=1 in every state except IDLE; busy is a combinational decode of state.
REQ-030 SHALL increment cnt on every edge where busy=1, saturate at 16'hFFFF, and hold its value in IDLE until the next accepted run.
REQ-031 SHALL cost 2 cycles per compare without a swap and 4 cycles per compare with a swap.

Reset
REQ-032 SHALL, on rstn low, immediately force state=IDLE, busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, cnt=0, and i, last, a_reg, b_reg, swapped to 0.
REQ-033 SHALL abort any sort in progress when reset asserts; RAM contents may be partially sorted and no further write occurs.
REQ-034 SHALL resume from IDLE on the first edge after rstn rises, accepting run at that edge.

Structure
REQ-035 SHALL take the state enum, the AW/DW defaults and the cnt width from the shared package sort_pkg.
REQ-036 SHALL implement the saturating cycle counter as the single sub-module sort_cycle_cnt (clear, enable, 16-bit saturating count).
REQ-037 SHALL keep the RAM and the switch/display muxing outside this block.

Verification
REQ-038 SHALL cover: N=4, RAM {1,2,3,4}, pulse run -> no writes, done pulse, cnt=7, RAM unchanged.
REQ-039 SHALL cover: N=4, RAM {4,3,2,1}, run -> final RAM {1,2,3,4}, 6 write pairs, cnt=25, busy high for 25 cycles.
REQ-040 SHALL cover: N=4, RAM {2,2,1,2}, ASCEND=0 -> final RAM {2,2,2,1}, with no equal-value swaps.
REQ-041 SHALL cover: run re-pulsed while busy -> ignored, and cnt matches the single-run value.
REQ-042 SHALL cover: rstn asserted mid-sort during WR_A -> mem_we drops the same cycle, busy=0, cnt=0, and a new run then completes correctly.
REQ-043 SHALL cover: N=256, RAM filled with 0xFFFF..0xFF00 descending -> ascending result, cnt=16'hFFFF (saturated), done asserted once.
